rx_cpl_host_mem: RTL

Receive-side partner of the huge-page read-request engine. Parses CplD TLPs arriving on the 64-bit TRN receive interface and matches each to its 5-bit request tag. Realigns the 3DW-header payload into qwords and writes them into the chunk buffer at a tag-indexed address. Pulses chunk_done when the final completion for a tag has landed.

---
 rtl/rx_cpl_host_mem_pkg.sv | 41 ++++
 rtl/rx_cpl_host_mem_cpl_tag_counters.sv | 33 +++
 rtl/rx_cpl_host_mem.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rx_cpl_host_mem_pkg.sv
// Shared constants for the CplD receive path: TLP type codes, status codes,
// header field positions on a 64-bit TRN beat, and the FSM state type.
package rx_cpl_host_mem_pkg;

    localparam int TAG_W = 5;
    localparam int NUM_TAGS = 1 << TAG_W;

    localparam logic [6:0] CPLD_FMT_TYPE = 7'b10_01010;
    localparam logic [6:0] CPL_FMT_TYPE  = 7'b00_01010;
    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [7:0] RREM_UPPER_DW = 8'h0F;

    // First beat carries {DW0, DW1}
    localparam int FMT_TYPE_HI = 62;
    localparam int FMT_TYPE_LO = 56;
    localparam int LEN_HI      = 41;
    localparam int LEN_LO      = 32;
    localparam int STATUS_HI   = 15;
    localparam int STATUS_LO   = 13;
    localparam int BC_HI       = 11;
    localparam int BC_LO       = 0;

    // Second beat carries {DW2, first payload DW}
    localparam int REQ_ID_HI = 63;
    localparam int REQ_ID_LO = 48;
    localparam int TAG_HI    = 44;
    localparam int TAG_LO    = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR2,
        ST_DATA,
        ST_DROP
    } state_e;

    // Byte count covering exactly this TLP's payload marks the final completion.
    function automatic logic is_last_cpl(logic [11:0] byte_cnt, logic [9:0] len_dw);
        return byte_cnt == {len_dw, 2'b00};
    endfunction

endpackage

// File: rtl/rx_cpl_host_mem_cpl_tag_counters.sv
// Per-tag qword offset counters. The extra top bit flags a full slot so the
// parent can refuse writes that would wrap into the start of the slot.
module cpl_tag_counters
    import rx_cpl_host_mem_pkg::*;
#(
    parameter int CHUNK_QW_LOG2 = 6,
    parameter int CNT_W         = CHUNK_QW_LOG2 + 1
) (
    input  logic             trn_clk,
    input  logic             reset_n,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic [CNT_W-1:0] o_rd_cnt,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic [TAG_W-1:0] i_wr_tag
);

    logic [CNT_W-1:0] r_cnt [NUM_TAGS];

    assign o_rd_cnt = r_cnt[i_rd_tag];

    // Clear wins so the final write of a chunk leaves the slot at zero.
    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAGS; i++) r_cnt[i] <= '0;
        end else if (i_clr) begin
            r_cnt[i_wr_tag] <= '0;
        end else if (i_inc) begin
            r_cnt[i_wr_tag] <= r_cnt[i_wr_tag] + 1'b1;
        end
    end

endmodule

// File: rtl/rx_cpl_host_mem.sv
// Receives CplD TLPs on the 64-bit TRN RX interface, realigns the 3DW-header
// payload into qwords and writes them to a tag-indexed chunk buffer.
module rx_cpl_host_mem
    import rx_cpl_host_mem_pkg::*;
#(
    parameter int CHUNK_QW_LOG2 = 6
) (
    input  logic                             trn_clk,
    input  logic                             reset_n,
    input  logic [63:0]                      trn_rd,
    input  logic [7:0]                       trn_rrem_n,
    input  logic                             trn_rsof_n,
    input  logic                             trn_reof_n,
    input  logic                             trn_rsrc_rdy_n,
    input  logic                             trn_rerrfwd_n,
    output logic                             trn_rdst_rdy_n,
    input  logic [15:0]                      cfg_completer_id,
    output logic                             buf_wr_en,
    output logic [TAG_W+CHUNK_QW_LOG2-1:0]   buf_wr_addr,
    output logic [63:0]                      buf_wr_data,
    output logic                             chunk_done,
    output logic [TAG_W-1:0]                 chunk_done_tag,
    output logic                             cpl_error
);

    localparam int CNT_W  = CHUNK_QW_LOG2 + 1;
    localparam int ADDR_W = TAG_W + CHUNK_QW_LOG2;

    state_e             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_held;
    logic               r_last;
    logic               r_rdst_rdy_n;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [63:0]        r_wr_data;
    logic               r_done;
    logic [TAG_W-1:0]   r_done_tag;
    logic               r_err;

    logic               w_beat;
    logic               w_sof;
    logic               w_eof;
    logic               w_poison;
    logic               w_odd_tail;
    logic               w_hdr1_ok;
    logic               w_hdr2_ok;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_ovf;
    logic               w_in_data;
    logic               w_inc;
    logic               w_clr;

    assign w_beat     = !trn_rsrc_rdy_n;
    assign w_sof      = !trn_rsof_n;
    assign w_eof      = !trn_reof_n;
    assign w_poison   = !trn_rerrfwd_n;
    assign w_odd_tail = trn_rrem_n != RREM_UPPER_DW;

    assign w_hdr1_ok = (trn_rd[FMT_TYPE_HI:FMT_TYPE_LO] == CPLD_FMT_TYPE)
                    && (trn_rd[STATUS_HI:STATUS_LO] == CPL_STATUS_SC) && !w_poison;
    assign w_hdr2_ok = (trn_rd[REQ_ID_HI:REQ_ID_LO] == cfg_completer_id) && !w_poison;

    // Counter control must act this cycle so back-to-back beats see the new offset.
    assign w_ovf     = w_cnt[CNT_W-1];
    assign w_in_data = w_beat && (r_state == ST_DATA);
    assign w_inc     = w_in_data && !w_poison && !w_ovf;
    assign w_clr     = w_in_data && (w_poison || (w_inc && w_eof && (w_odd_tail || r_last)));

    cpl_tag_counters #(
        .CHUNK_QW_LOG2 (CHUNK_QW_LOG2),
        .CNT_W         (CNT_W)
    ) u_cnt (
        .trn_clk  (trn_clk),
        .reset_n  (reset_n),
        .i_rd_tag (r_tag),
        .o_rd_cnt (w_cnt),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .i_wr_tag (r_tag)
    );

    always_ff @(posedge trn_clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_held       <= '0;
            r_last       <= 1'b0;
            r_rdst_rdy_n <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_done       <= 1'b0;
            r_done_tag   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rdst_rdy_n <= 1'b0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            if (w_beat) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_sof) begin
                            r_last <= is_last_cpl(trn_rd[BC_HI:BC_LO], trn_rd[LEN_HI:LEN_LO]);
                            if (w_hdr1_ok && !w_eof) begin
                                r_state <= ST_HDR2;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= w_eof ? ST_IDLE : ST_DROP;
                            end
                        end
                    end
                    ST_HDR2: begin
                        if (w_hdr2_ok && !w_eof) begin
                            r_tag   <= trn_rd[TAG_HI:TAG_LO];
                            r_held  <= trn_rd[31:0];
                            r_state <= ST_DATA;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= w_eof ? ST_IDLE : ST_DROP;
                        end
                    end
                    ST_DATA: begin
                        if (w_inc) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {r_tag, w_cnt[CHUNK_QW_LOG2-1:0]};
                            r_wr_data <= {r_held, trn_rd[63:32]};
                            r_held    <= trn_rd[31:0];
                            if (w_eof) begin
                                r_state <= ST_IDLE;
                                // An odd DW count leaves a dangling DW; the chunk can't be trusted.
                                if (w_odd_tail) begin
                                    r_err <= 1'b1;
                                end else if (r_last) begin
                                    r_done     <= 1'b1;
                                    r_done_tag <= r_tag;
                                end
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= w_eof ? ST_IDLE : ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (w_eof) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign trn_rdst_rdy_n = r_rdst_rdy_n;
    assign buf_wr_en      = r_wr_en;
    assign buf_wr_addr    = r_wr_addr;
    assign buf_wr_data    = r_wr_data;
    assign chunk_done     = r_done;
    assign chunk_done_tag = r_done_tag;
    assign cpl_error      = r_err;

endmodule
